// File: rtl/rps_pkg.sv
// Shared definitions for the Rock-Paper-Scissors match sequencer.
//
// Contents:
//   CHOICE_*       player-choice encoding as produced by the choice encoder
//   match_state_e  match sequencer state
//   result_e       decoded round result from the controller LEDs
//   decode_result  maps {win_led, lose_led} to a result_e
//   cnt_width      counter width needed to hold (cycles - 1), at least 1 bit

package rps_pkg;

    localparam logic [1:0] CHOICE_NONE     = 2'b00;
    localparam logic [1:0] CHOICE_ROCK     = 2'b01;
    localparam logic [1:0] CHOICE_PAPER    = 2'b10;
    localparam logic [1:0] CHOICE_SCISSORS = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StWaitChoice,
        StThink,
        StStop,
        StEval,
        StHold,
        StDone
    } match_state_e;

    typedef enum logic [1:0] {
        ResWin,
        ResLose,
        ResTie,
        ResErr
    } result_e;

    function automatic result_e decode_result(input logic win, input logic lose);
        result_e res;
        unique case ({win, lose})
            2'b10:   res = ResWin;
            2'b01:   res = ResLose;
            2'b11:   res = ResErr;
            default: res = ResTie;
        endcase
        return res;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/rps_down_counter.sv
// Loadable down-counter with a zero flag.
//
// Ports:
//   clock       system clock
//   reset_n     asynchronous active-low reset (count returns to 0)
//   load        load load_value this cycle (has priority over enable)
//   load_value  value to load
//   enable      decrement by one; holds at 0
//   zero        high while the count is 0

module rps_down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (enable && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/rps_match_sequencer.sv
// Match-level master for the Rock-Paper-Scissors game controller. Sequences rounds by driving
// the controller's reset and stop inputs, scores each round from its win/lose LEDs, and
// declares the match winner at first-to-ROUNDS_TO_WIN.
//
// Optional build macro: MATCH_TIMEOUT_EN -- forfeits a round to the CPU when the player makes
// no choice within TIMEOUT_CYCLES of entering WAIT_CHOICE.
//
// Ports:
//   clock             system clock
//   reset_n           asynchronous active-low reset
//   start             pulse, begins a new match from IDLE or DONE
//   player_choice     player choice, 00 = none
//   win_led/lose_led  controller round result
//   game_reset        controller reset_button (active-high)
//   stop_signal       controller stop/lock-in
//   player_score      player round wins this match
//   cpu_score         CPU round wins this match
//   round_count       rounds evaluated this match (saturating)
//   busy              high outside IDLE and DONE
//   match_done        high in DONE
//   player_won_match  match winner, valid while match_done
//   result_error      sticky: both LEDs seen high at evaluation

module rps_match_sequencer
    import rps_pkg::*;
#(
    parameter int unsigned ROUNDS_TO_WIN  = 2,
    parameter int unsigned THINK_CYCLES   = 16,
    parameter int unsigned RESULT_HOLD    = 8,
    parameter int unsigned SCORE_W        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         player_choice,
    input  logic               win_led,
    input  logic               lose_led,
    output logic               game_reset,
    output logic               stop_signal,
    output logic [SCORE_W-1:0] player_score,
    output logic [SCORE_W-1:0] cpu_score,
    output logic [SCORE_W-1:0] round_count,
    output logic               busy,
    output logic               match_done,
    output logic               player_won_match,
    output logic               result_error
);

    localparam int unsigned THINK_W = cnt_width(THINK_CYCLES);
    localparam int unsigned HOLD_W  = cnt_width(RESULT_HOLD);
    localparam logic [SCORE_W-1:0] WIN_TARGET = SCORE_W'(ROUNDS_TO_WIN);

    match_state_e       state_q, state_d;
    logic [SCORE_W-1:0] player_score_q, player_score_d;
    logic [SCORE_W-1:0] cpu_score_q, cpu_score_d;
    logic [SCORE_W-1:0] round_count_q, round_count_d;
    logic               result_error_q, result_error_d;
    logic               won_q, won_d;
    logic               stop_second_q, stop_second_d;
    logic               game_reset_q, stop_q, busy_q, done_q;

    logic    think_load, think_zero;
    logic    hold_load, hold_zero;
    result_e eval_result;

    assign eval_result = decode_result(win_led, lose_led);

    rps_down_counter #(
        .WIDTH(THINK_W)
    ) u_think_cnt (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (think_load),
        .load_value(THINK_W'(THINK_CYCLES - 1)),
        .enable    (state_q == StThink),
        .zero      (think_zero)
    );

    rps_down_counter #(
        .WIDTH(HOLD_W)
    ) u_hold_cnt (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (hold_load),
        .load_value(HOLD_W'(RESULT_HOLD - 1)),
        .enable    (state_q == StHold),
        .zero      (hold_zero)
    );

`ifdef MATCH_TIMEOUT_EN
    localparam int unsigned TIMEOUT_W = cnt_width(TIMEOUT_CYCLES);

    logic timeout_load, timeout_zero;

    // Loaded only from CLEAR, so a choice withdrawn in THINK resumes the same countdown.
    rps_down_counter #(
        .WIDTH(TIMEOUT_W)
    ) u_timeout_cnt (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (timeout_load),
        .load_value(TIMEOUT_W'(TIMEOUT_CYCLES - 1)),
        .enable    (state_q == StWaitChoice),
        .zero      (timeout_zero)
    );
`endif

    always_comb begin
        state_d        = state_q;
        player_score_d = player_score_q;
        cpu_score_d    = cpu_score_q;
        round_count_d  = round_count_q;
        result_error_d = result_error_q;
        won_d          = won_q;
        // Second STOP cycle is flagged so STOP lasts exactly two cycles.
        stop_second_d  = (state_q == StStop) && !stop_second_q;
        think_load     = 1'b0;
        hold_load      = 1'b0;
`ifdef MATCH_TIMEOUT_EN
        timeout_load   = 1'b0;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d        = StClear;
                    player_score_d = '0;
                    cpu_score_d    = '0;
                    round_count_d  = '0;
                    result_error_d = 1'b0;
                    won_d          = 1'b0;
                end
            end
            StClear: begin
                state_d = StWaitChoice;
`ifdef MATCH_TIMEOUT_EN
                timeout_load = 1'b1;
`endif
            end
            StWaitChoice: begin
                if (player_choice != CHOICE_NONE) begin
                    state_d    = StThink;
                    think_load = 1'b1;
                end
`ifdef MATCH_TIMEOUT_EN
                else if (timeout_zero) begin
                    // Forfeit: score the round for the CPU and go straight to HOLD.
                    state_d       = StHold;
                    hold_load     = 1'b1;
                    cpu_score_d   = cpu_score_q + 1'b1;
                    round_count_d = (round_count_q == '1) ? round_count_q
                                                          : round_count_q + 1'b1;
                end
`endif
            end
            StThink: begin
                if (player_choice == CHOICE_NONE) begin
                    state_d = StWaitChoice;
                end else if (think_zero) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (stop_second_q) begin
                    state_d = StEval;
                end
            end
            StEval: begin
                unique case (eval_result)
                    ResWin:  player_score_d = player_score_q + 1'b1;
                    ResLose: cpu_score_d    = cpu_score_q + 1'b1;
                    ResErr:  result_error_d = 1'b1;
                    default: ;
                endcase
                round_count_d = (round_count_q == '1) ? round_count_q : round_count_q + 1'b1;
                hold_load     = 1'b1;
                state_d       = StHold;
            end
            StHold: begin
                if (hold_zero) begin
                    if (player_score_q == WIN_TARGET) begin
                        state_d = StDone;
                        won_d   = 1'b1;
                    end else if (cpu_score_q == WIN_TARGET) begin
                        state_d = StDone;
                        won_d   = 1'b0;
                    end else begin
                        state_d = StClear;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control outputs are registered from the next state so they align with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            player_score_q <= '0;
            cpu_score_q    <= '0;
            round_count_q  <= '0;
            result_error_q <= 1'b0;
            won_q          <= 1'b0;
            stop_second_q  <= 1'b0;
            game_reset_q   <= 1'b1;
            stop_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            player_score_q <= player_score_d;
            cpu_score_q    <= cpu_score_d;
            round_count_q  <= round_count_d;
            result_error_q <= result_error_d;
            won_q          <= won_d;
            stop_second_q  <= stop_second_d;
            game_reset_q   <= (state_d inside {StIdle, StClear, StDone});
            stop_q         <= (state_d inside {StStop, StEval, StHold});
            busy_q         <= !(state_d inside {StIdle, StDone});
            done_q         <= (state_d == StDone);
        end
    end

    assign game_reset       = game_reset_q;
    assign stop_signal      = stop_q;
    assign player_score     = player_score_q;
    assign cpu_score        = cpu_score_q;
    assign round_count      = round_count_q;
    assign busy             = busy_q;
    assign match_done       = done_q;
    assign player_won_match = won_q;
    assign result_error     = result_error_q;

endmodule

// File: tb/tb_rps_match_sequencer.sv
// Scoreboard bench for rps_match_sequencer: each round/match pushes its hand-computed result,
// and a negedge monitor pops and compares when round_count advances or match_done rises.

module tb_rps_match_sequencer;
    import rps_pkg::*;

    localparam int unsigned THINK = 4;
    localparam int unsigned HOLD  = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] player_choice = 2'b00;
    logic       win_led = 1'b0;
    logic       lose_led = 1'b0;
    logic       game_reset, stop_signal, busy, match_done, player_won_match, result_error;
    logic [3:0] player_score, cpu_score, round_count;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [3:0] p;
        logic [3:0] c;
        logic [3:0] r;
        logic       err;
    } round_exp_t;

    typedef struct packed {
        logic       won;
        logic [3:0] p;
        logic [3:0] c;
    } match_exp_t;

    round_exp_t round_q[$];
    match_exp_t match_q[$];

    rps_match_sequencer #(
        .ROUNDS_TO_WIN (2),
        .THINK_CYCLES  (THINK),
        .RESULT_HOLD   (HOLD),
        .SCORE_W       (4),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .player_choice   (player_choice),
        .win_led         (win_led),
        .lose_led        (lose_led),
        .game_reset      (game_reset),
        .stop_signal     (stop_signal),
        .player_score    (player_score),
        .cpu_score       (cpu_score),
        .round_count     (round_count),
        .busy            (busy),
        .match_done      (match_done),
        .player_won_match(player_won_match),
        .result_error    (result_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor
    logic [3:0] prev_rc = '0;
    logic       prev_done = 1'b0;

    always @(negedge clock) begin
        round_exp_t re;
        match_exp_t me;
        if (!reset_n) begin
            prev_rc   <= '0;
            prev_done <= 1'b0;
        end else begin
            if (round_count != prev_rc && round_count != 0) begin
                if (round_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL round_unexpected: round_count=%0d with no expected round",
                             round_count);
                end else begin
                    re = round_q.pop_front();
                    check("round_player_score", int'(player_score), int'(re.p));
                    check("round_cpu_score", int'(cpu_score), int'(re.c));
                    check("round_count", int'(round_count), int'(re.r));
                    check("round_result_error", int'(result_error), int'(re.err));
                end
            end
            if (match_done && !prev_done) begin
                if (match_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL match_unexpected: match_done with no expected match");
                end else begin
                    me = match_q.pop_front();
                    check("match_player_won", int'(player_won_match), int'(me.won));
                    check("match_player_score", int'(player_score), int'(me.p));
                    check("match_cpu_score", int'(cpu_score), int'(me.c));
                end
            end
            prev_rc   <= round_count;
            prev_done <= match_done;
        end
    end

    task automatic wait_stop(input logic level, input string name);
        int n = 0;
        while (stop_signal !== level && n < 100) begin
            @(negedge clock);
            n++;
        end
        check(name, int'(stop_signal), int'(level));
    endtask

    // Returns 1 ns after the edge that samples start.
    task automatic pulse_start();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic play_round(input logic [1:0] choice, input logic win, input logic lose,
                              input int p, input int c, input int r, input logic err);
        round_q.push_back('{p: 4'(p), c: 4'(c), r: 4'(r), err: err});
        @(posedge clock);
        #1 player_choice = choice;
        wait_stop(1'b1, "stop_rise_timeout");
        win_led  = win;
        lose_led = lose;
        wait_stop(1'b0, "stop_fall_timeout");
        win_led       = 1'b0;
        lose_led      = 1'b0;
        player_choice = CHOICE_NONE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   cnt;
        logic stop_seen;

        // Reset state
        repeat (2) @(negedge clock);
        check("reset_game_reset", int'(game_reset), 1);
        check("reset_stop", int'(stop_signal), 0);
        check("reset_player_score", int'(player_score), 0);
        check("reset_cpu_score", int'(cpu_score), 0);
        check("reset_round_count", int'(round_count), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_match_done", int'(match_done), 0);
        check("reset_result_error", int'(result_error), 0);
        reset_n = 1'b1;

        // Match 1: player wins 2-0; game_reset pulse and stop latency
        match_q.push_back('{won: 1'b1, p: 4'd2, c: 4'd0});
        pulse_start();
        @(negedge clock);
        check("clear_game_reset_high", int'(game_reset), 1);
        check("clear_busy", int'(busy), 1);
        @(negedge clock);
        check("wait_game_reset_low", int'(game_reset), 0);

        round_q.push_back('{p: 4'd1, c: 4'd0, r: 4'd1, err: 1'b0});
        @(posedge clock);
        #1 player_choice = CHOICE_ROCK;
        @(posedge clock);
        cnt = 0;
        do begin
            @(posedge clock);
            #1 cnt++;
        end while (!stop_signal && cnt < 50);
        check("stop_latency_edges", cnt, THINK);
        win_led = 1'b1;
        wait_stop(1'b0, "stop_fall_timeout");
        win_led       = 1'b0;
        player_choice = CHOICE_NONE;

        // start while busy must be ignored
        pulse_start();
        @(negedge clock);
        check("busy_start_game_reset", int'(game_reset), 0);
        check("busy_start_keeps_score", int'(player_score), 1);
        play_round(CHOICE_PAPER, 1'b1, 1'b0, 2, 0, 2, 1'b0);
        @(negedge clock);
        check("match1_done", int'(match_done), 1);

        // Match 2: tie, lose, lose
        pulse_start();
        @(negedge clock);
        check("restart_clears_score", int'(player_score), 0);
        check("restart_clears_done", int'(match_done), 0);
        match_q.push_back('{won: 1'b0, p: 4'd0, c: 4'd2});
        play_round(CHOICE_SCISSORS, 1'b0, 1'b0, 0, 0, 1, 1'b0);
        play_round(CHOICE_ROCK, 1'b0, 1'b1, 0, 1, 2, 1'b0);
        play_round(CHOICE_PAPER, 1'b0, 1'b1, 0, 2, 3, 1'b0);

        // Match 3: both LEDs high, then two wins
        pulse_start();
        match_q.push_back('{won: 1'b1, p: 4'd2, c: 4'd0});
        play_round(CHOICE_ROCK, 1'b1, 1'b1, 0, 0, 1, 1'b1);
        play_round(CHOICE_ROCK, 1'b1, 1'b0, 1, 0, 2, 1'b1);
        play_round(CHOICE_ROCK, 1'b1, 1'b0, 2, 0, 3, 1'b1);
        @(negedge clock);
        check("err_sticky_at_done", int'(result_error), 1);
        pulse_start();
        @(negedge clock);
        check("err_cleared_on_start", int'(result_error), 0);

        // Match 4: choice withdrawn mid-THINK
        @(posedge clock);
        #1 player_choice = CHOICE_ROCK;
        repeat (2) @(posedge clock);
        #1 player_choice = CHOICE_NONE;
        stop_seen = 1'b0;
        repeat (5) begin
            @(negedge clock);
            stop_seen |= stop_signal;
        end
        check("withdraw_no_stop", int'(stop_seen), 0);
        check("withdraw_still_busy", int'(busy), 1);
        check("withdraw_game_reset_low", int'(game_reset), 0);
        play_round(CHOICE_ROCK, 1'b1, 1'b0, 1, 0, 1, 1'b0);

        // Async reset mid-HOLD
        round_q.push_back('{p: 4'd1, c: 4'd1, r: 4'd2, err: 1'b0});
        @(posedge clock);
        #1 player_choice = CHOICE_PAPER;
        wait_stop(1'b1, "stop_rise_timeout");
        lose_led = 1'b1;
        repeat (4) @(posedge clock);
        #2;
        check("in_hold_stop", int'(stop_signal), 1);
        reset_n = 1'b0;
        #1;
        check("async_reset_stop", int'(stop_signal), 0);
        check("async_reset_player_score", int'(player_score), 0);
        check("async_reset_cpu_score", int'(cpu_score), 0);
        check("async_reset_round_count", int'(round_count), 0);
        check("async_reset_game_reset", int'(game_reset), 1);
        check("async_reset_busy", int'(busy), 0);
        lose_led      = 1'b0;
        player_choice = CHOICE_NONE;
        @(negedge clock);
        reset_n = 1'b1;

`ifdef MATCH_TIMEOUT_EN
        // Timeout forfeit after 10 cycles in WAIT_CHOICE
        round_q.push_back('{p: 4'd0, c: 4'd1, r: 4'd1, err: 1'b0});
        pulse_start();
        @(posedge clock);
        stop_seen = 1'b0;
        repeat (10) begin
            @(negedge clock);
            stop_seen |= stop_signal;
        end
        check("timeout_wait_no_stop", int'(stop_seen), 0);
        check("timeout_before_forfeit", int'(cpu_score), 0);
        @(negedge clock);
        check("timeout_forfeit_cpu", int'(cpu_score), 1);
        check("timeout_forfeit_round", int'(round_count), 1);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
`endif

        repeat (3) @(negedge clock);
        check("round_queue_drained", round_q.size(), 0);
        check("match_queue_drained", match_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rps_match_sequencer.md
Name: rps_match_sequencer

Overview:
- Match-level master for the Rock-Paper-Scissors game controller. Drives its round-reset and stop/lock-in inputs, and reads back its win/lose LED outputs.
- Sequences rounds, keeps player and CPU scores, and declares the match winner at first-to-ROUNDS_TO_WIN.
- Sits above the game controller; it is the other end of that controller's control/result interface.

Parameters:
- ROUNDS_TO_WIN, 2, round wins needed to take the match (best-of-3 default); legal 1..(2^SCORE_W-1).
- THINK_CYCLES, 16, cycles the CPU choice runs free after the player locks a choice, before stop asserts; minimum 1.
- RESULT_HOLD, 8, cycles stop is held and the result is shown before the next round; minimum 1.
- SCORE_W, 4, width of score and round counters.
- TIMEOUT_CYCLES, 1000, player choice timeout; used only with MATCH_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse, begins a new match; ignored unless in IDLE or DONE
- player_choice  in  2  player choice from the player-choice encoder; 00 means none
- win_led  in  1  controller win result
- lose_led  in  1  controller loss result
- game_reset  out  1  drives the controller reset_button; active-high
- stop_signal  out  1  drives the controller stop_signal
- player_score  out  SCORE_W  player round wins this match
- cpu_score  out  SCORE_W  CPU round wins this match
- round_count  out  SCORE_W  rounds evaluated this match, ties included
- busy  out  1  high in every state except IDLE and DONE
- match_done  out  1  high in DONE
- player_won_match  out  1  valid while match_done; 1 means the player won
- result_error  out  1  sticky per match; set when win_led and lose_led are both high at EVAL

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, game_reset=1, stop_signal=0, all scores and counters 0, busy=0, match_done=0, player_won_match=0, result_error=0.
- States: IDLE, CLEAR, WAIT_CHOICE, THINK, STOP, EVAL, HOLD, DONE.
- IDLE: game_reset=1. start -> CLEAR, and clears player_score, cpu_score, round_count and result_error in the same edge.
- CLEAR: exactly 1 cycle. game_reset=1, stop_signal=0 -> WAIT_CHOICE.
- WAIT_CHOICE: game_reset=0, stop_signal=0. Waits for player_choice!=00, then -> THINK and loads the think counter with THINK_CYCLES-1.
- THINK: counter decrements each cycle.
  - player_choice returns to 00 -> back to WAIT_CHOICE (choice withdrawn).
  - Counter reaching 0 -> STOP.
- STOP: stop_signal=1. Lasts exactly 2 cycles so the controller's LED outputs settle -> EVAL.
- EVAL: 1 cycle, stop_signal stays 1. Samples win_led and lose_led:
  - win=1, lose=0: player_score+1.
  - win=0, lose=1: cpu_score+1.
  - win=0, lose=0: tie, no score change.
  - win=1, lose=1: treated as a tie, result_error set.
  - round_count+1, saturating at all-ones.
  - Loads the hold counter with RESULT_HOLD-1 -> HOLD.
- HOLD: stop_signal=1; counts down to 0. Then:
  - player_score==ROUNDS_TO_WIN -> DONE with player_won_match=1.
  - cpu_score==ROUNDS_TO_WIN -> DONE with player_won_match=0.
  - Otherwise -> CLEAR (next round; scores kept).
- DONE: match_done=1, stop_signal=0, game_reset=1. Scores remain visible. start -> CLEAR with scores cleared, as from IDLE.
- start while busy is ignored; no queuing.
- Scores cannot exceed ROUNDS_TO_WIN, so they never wrap.
- Deasserting reset_n mid-match immediately returns all outputs to their reset values, regardless of state.
- Latency: start at edge N gives game_reset=1 during cycle N+1 and game_reset=0 from N+2.
  - Player choice seen at edge M gives stop_signal rising at edge M+THINK_CYCLES.

Optional Feature:
- MATCH_TIMEOUT_EN defined:
  - A timeout counter loads TIMEOUT_CYCLES-1 on entry to WAIT_CHOICE.
  - If it reaches 0 with player_choice==00, the round is forfeited: cpu_score+1, round_count+1, -> HOLD. The THINK, STOP and EVAL states are skipped.
  - Re-entry to WAIT_CHOICE from THINK does not reload the timer.
- MATCH_TIMEOUT_EN undefined: WAIT_CHOICE waits indefinitely; no timeout logic exists and TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package rps_pkg:
  - Choice encoding: CHOICE_NONE=2'b00, CHOICE_ROCK=2'b01, CHOICE_PAPER=2'b10, CHOICE_SCISSORS=2'b11.
  - Match state enum typedef.
  - Result enum (WIN/LOSE/TIE/ERR).
- One natural sub-module, rps_down_counter: loadable down-counter with a zero flag. Reused for the think, hold and timeout counts.

Test Plan:
- Reset, then start; choice=01 held; win_led=1 at EVAL; THINK_CYCLES=4 -> game_reset high exactly 1 cycle, stop rises 4 cycles after choice, player_score=1, round_count=1.
- Player wins two rounds with ROUNDS_TO_WIN=2 -> match_done=1, player_won_match=1, player_score=2, cpu_score=0; a start pulse while busy has no effect.
- Sequence tie, lose, lose -> round_count=3, cpu_score=2, player_won_match=0, player_score=0.
- win_led=lose_led=1 at EVAL -> result_error=1, no score change; cleared on next start.
- Choice dropped to 00 mid-THINK -> returns to WAIT_CHOICE, stop_signal never asserts; reset_n low mid-HOLD -> stop_signal=0 and scores=0 asynchronously.
- MATCH_TIMEOUT_EN with TIMEOUT_CYCLES=10, no choice -> cpu_score=1 after 10 cycles in WAIT_CHOICE, stop_signal stays 0.
